// File: rtl/vx_tcu_bhf_fp8mul_ctrl.sv
// Time-multiplexes a block of FP8 operand pairs over a small set of external
// multiplier lanes and buffers the recoded products for the BHF accumulate stage.
module vx_tcu_bhf_fp8mul_ctrl #(
    parameter int NUM_ELEMS = 8,
    parameter int NUM_LANES = 2,
    parameter int REC_WIDTH = 17
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ELEMS*8-1:0]         in_a,
    input  logic [NUM_ELEMS*8-1:0]         in_b,
    output logic                           mul_en,
    output logic [NUM_LANES*8-1:0]         mul_a,
    output logic [NUM_LANES*8-1:0]         mul_b,
    input  logic [NUM_LANES*REC_WIDTH-1:0] mul_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ELEMS*REC_WIDTH-1:0] out_prod,
    output logic                           busy
);

    localparam int PASSES = NUM_ELEMS / NUM_LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int IDX_W  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             a_q    [NUM_ELEMS];
    logic [7:0]             a_d    [NUM_ELEMS];
    logic [7:0]             b_q    [NUM_ELEMS];
    logic [7:0]             b_d    [NUM_ELEMS];
    logic [REC_WIDTH-1:0]   prod_q [NUM_ELEMS];
    logic [REC_WIDTH-1:0]   prod_d [NUM_ELEMS];
    logic [IDX_W-1:0]       lane_idx [NUM_LANES];
    logic                   accept;

    // Lane gi of pass cnt handles element cnt*NUM_LANES + gi.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_idx[gi]       = IDX_W'(int'(cnt_q) * NUM_LANES + gi);
            assign mul_a[gi*8 +: 8]   = mul_en ? a_q[lane_idx[gi]] : 8'd0;
            assign mul_b[gi*8 +: 8]   = mul_en ? b_q[lane_idx[gi]] : 8'd0;
        end
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_out
            assign out_prod[gi*REC_WIDTH +: REC_WIDTH] = prod_q[gi];
        end
    endgenerate

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        mul_en    = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ISSUE: begin
                mul_en = 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    prod_d[lane_idx[l]] = mul_y[l*REC_WIDTH +: REC_WIDTH];
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Only a completed handshake frees the buffer for the next block.
                if (out_ready) begin
                    in_ready = in_valid;
                    accept   = in_valid;
                    if (!in_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = ISSUE;
            cnt_d   = '0;
            for (int e = 0; e < NUM_ELEMS; e++) begin
                a_d[e] = in_a[e*8 +: 8];
                b_d[e] = in_b[e*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            prod_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

endmodule
